// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter moving one packet per grant from a source FIFO to one
// or all destination FIFOs through an IDLE/WAIT/XFER/GAP handshake.
module bus_rr_arbiter #(
  parameter int         num_ntrfs = 4,
  parameter int         pckg_sz   = 32,
  parameter logic [7:0] broadcast = {8{1'b1}}
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [num_ntrfs-1:0]              pndng_i_in,
  input  logic [num_ntrfs-1:0][pckg_sz-1:0] data_out_i_in,
  input  logic [num_ntrfs-1:0]              dst_full,
  output logic [num_ntrfs-1:0]              popin,
  output logic [num_ntrfs-1:0]              push,
  output logic [pckg_sz-1:0]                bus_data,
  output logic [3:0]                        grant_id,
  output logic                              busy,
  output logic                              drop
);

  localparam int iw = (num_ntrfs > 1) ? $clog2(num_ntrfs) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, XFER, GAP} state_t;

  state_t               state_reg, state_next;
  logic [3:0]           last_grant_reg;
  logic [3:0]           rr_pick;
  logic                 rr_found;
  logic [4:0]           rr_idx;
  logic [7:0]           dst_id;
  logic                 is_bcast;
  logic                 id_valid;
  logic                 blocked;
  logic [num_ntrfs-1:0] target;
  logic                 pop_en;
  logic                 push_en;
  logic                 drop_en;

  // Cyclic search from last_grant+1; iterating backwards lets the nearest hit win.
  always_comb begin
    rr_found = 1'b0;
    rr_pick  = '0;
    rr_idx   = '0;
    for (int k = num_ntrfs; k >= 1; k--) begin
      rr_idx = {1'b0, last_grant_reg} + 5'(k);
      if (rr_idx >= 5'(num_ntrfs)) begin
        rr_idx = rr_idx - 5'(num_ntrfs);
      end
      if (pndng_i_in[rr_idx[iw-1:0]]) begin
        rr_found = 1'b1;
        rr_pick  = 4'(rr_idx);
      end
    end
  end

  assign dst_id   = bus_data[pckg_sz-1 -: 8];
  assign is_bcast = (dst_id == broadcast);
  assign id_valid = is_bcast || (dst_id < 8'(num_ntrfs));
  assign blocked  = |(target & dst_full);

  // Strobes are masked by reset so an aborted transfer never pops or pushes.
  for (genvar gi = 0; gi < num_ntrfs; gi++) begin : g_term
    assign target[gi] = is_bcast ? (grant_id != 4'(gi)) : (dst_id == 8'(gi));
    assign popin[gi]  = pop_en && !reset && (grant_id == 4'(gi));
    assign push[gi]   = push_en && !reset && target[gi];
  end

  assign drop = drop_en && !reset;
  assign busy = (state_reg != IDLE);

  always_comb begin
    state_next = state_reg;
    pop_en     = 1'b0;
    push_en    = 1'b0;
    drop_en    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (rr_found) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (!id_valid) begin
          drop_en    = 1'b1;
          pop_en     = 1'b1;
          state_next = GAP;
        end else if (!blocked) begin
          state_next = XFER;
        end
      end
      XFER: begin
        pop_en     = 1'b1;
        push_en    = 1'b1;
        state_next = GAP;
      end
      GAP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      bus_data       <= '0;
      grant_id       <= '0;
      last_grant_reg <= 4'(num_ntrfs - 1);
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && rr_found) begin
        grant_id <= rr_pick;
        bus_data <= data_out_i_in[rr_pick[iw-1:0]];
      end
      if (state_reg == XFER) begin
        last_grant_reg <= grant_id;
      end
    end
  end

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Directed stimulus for bus_rr_arbiter; expected transfers are queued by the
// stimulus and matched by a monitor whenever the arbiter strobes pop/push/drop.
module tb_bus_rr_arbiter;

  logic             clk = 1'b0;
  logic             reset;
  logic [3:0]       pndng_i_in;
  logic [3:0][31:0] data_out_i_in;
  logic [3:0]       dst_full;
  logic [3:0]       popin;
  logic [3:0]       push;
  logic [31:0]      bus_data;
  logic [3:0]       grant_id;
  logic             busy;
  logic             drop;

  typedef struct {
    logic [3:0]  popin;
    logic [3:0]  push;
    logic [31:0] data;
    logic        drop;
    logic [3:0]  gid;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  bus_rr_arbiter #(.num_ntrfs(4), .pckg_sz(32), .broadcast(8'hFF)) dut (
    .clk(clk),
    .reset(reset),
    .pndng_i_in(pndng_i_in),
    .data_out_i_in(data_out_i_in),
    .dst_full(dst_full),
    .popin(popin),
    .push(push),
    .bus_data(bus_data),
    .grant_id(grant_id),
    .busy(busy),
    .drop(drop)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset && (popin != 4'b0 || push != 4'b0 || drop)) begin
      $display("txn cyc=%0d grant=%0d popin=%b push=%b drop=%b data=%h",
               cyc, grant_id, popin, push, drop, bus_data);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_txn actual popin=%b push=%b drop=%b required none", popin, push, drop);
      end else begin
        mon_e = sb.pop_front();
        check("txn_popin", popin, mon_e.popin);
        check("txn_push", push, mon_e.push);
        check("txn_drop", drop, mon_e.drop);
        check("txn_bus_data", bus_data, mon_e.data);
        check("txn_grant_id", grant_id, mon_e.gid);
        check("txn_cycle", cyc, mon_e.cyc);
      end
    end
  end

  task automatic expect_txn(input int src, input logic [3:0] p, input logic [31:0] d,
                            input logic dr, input int at_cyc);
    exp_t e;
    e.popin = 4'(1 << src);
    e.push  = p;
    e.data  = d;
    e.drop  = dr;
    e.gid   = 4'(src);
    e.cyc   = at_cyc;
    sb.push_back(e);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 30) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_pop(input int src, input bit clr);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!popin[src] && n < 60);
    check("pop_seen", popin[src], 1'b1);
    if (clr) pndng_i_in[src] = 1'b0;
  endtask

  task automatic apply_reset(input int n);
    reset = 1'b1;
    repeat (n) tick();
    check("rst_popin", popin, 4'b0);
    check("rst_push", push, 4'b0);
    check("rst_drop", drop, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_bus_data", bus_data, 32'h0);
    check("rst_grant_id", grant_id, 4'h0);
    reset = 1'b0;
  endtask

  // One packet from src; full_n>0 holds full_mask on the destinations that long.
  task automatic send(input int src, input logic [31:0] pkt, input logic [3:0] exp_push,
                      input logic exp_drop, input int full_n, input logic [3:0] full_mask);
    int lat;
    wait_idle();
    lat = exp_drop ? 1 : ((full_n > 0) ? full_n + 1 : 2);
    data_out_i_in[src] = pkt;
    pndng_i_in[src]    = 1'b1;
    dst_full           = (full_n > 0) ? full_mask : 4'b0;
    expect_txn(src, exp_push, pkt, exp_drop, cyc + lat);
    for (int k = 0; k < full_n; k++) begin
      tick();
      check("bp_busy", busy, 1'b1);
      check("bp_popin", popin, 4'b0);
      check("bp_push", push, 4'b0);
    end
    dst_full = 4'b0;
    wait_pop(src, 1'b1);
  endtask

  initial begin
    int base;
    reset         = 1'b1;
    pndng_i_in    = 4'b0;
    data_out_i_in = '0;
    dst_full      = 4'b0;
    apply_reset(3);

    // single packet, broadcast, self-addressed, invalid id, back-pressure
    send(1, 32'h0200ABCD, 4'b0100, 1'b0, 0, 4'b0);
    send(2, 32'hFF001234, 4'b1011, 1'b0, 0, 4'b0);
    send(0, 32'h00005555, 4'b0001, 1'b0, 0, 4'b0);
    send(3, 32'h0700BEEF, 4'b0000, 1'b1, 0, 4'b0);
    send(0, 32'h0300C0DE, 4'b1000, 1'b0, 10, 4'b1000);

    // reset while source 3 is parked in WAIT behind a full destination
    wait_idle();
    data_out_i_in[3] = 32'h02003333;
    pndng_i_in[3]    = 1'b1;
    dst_full         = 4'b0100;
    tick();
    tick();
    check("wait_grant_id", grant_id, 4'd3);
    check("wait_busy", busy, 1'b1);
    check("wait_push", push, 4'b0);
    data_out_i_in[1] = 32'h00001111;
    pndng_i_in[1]    = 1'b1;
    apply_reset(1);
    dst_full = 4'b0;
    base = cyc;
    expect_txn(1, 4'b0001, 32'h00001111, 1'b0, base + 2);
    expect_txn(3, 4'b0100, 32'h02003333, 1'b0, base + 6);
    wait_pop(1, 1'b1);
    wait_pop(3, 1'b1);

    // fairness: all four request continuously
    wait_idle();
    apply_reset(2);
    for (int i = 0; i < 4; i++) begin
      data_out_i_in[i] = {8'((i + 1) % 4), 24'hF00000 + 24'(i)};
    end
    pndng_i_in = 4'b1111;
    base = cyc;
    for (int i = 0; i < 5; i++) begin
      expect_txn(i % 4, 4'(1 << ((i % 4 + 1) % 4)),
                 {8'((i % 4 + 1) % 4), 24'hF00000 + 24'(i % 4)}, 1'b0, base + 2 + 4 * i);
    end
    for (int i = 0; i < 5; i++) begin
      wait_pop(i % 4, 1'b0);
    end
    pndng_i_in = 4'b0;

    repeat (10) tick();
    check("scoreboard_drained", sb.size(), 0);
    check("final_idle", busy, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
